// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module  : pipe_stage_buf
// Purpose : Parametrised pipeline-stage register with valid/ready handshake,
//           flush, optional 2-entry skid buffer, a side lane that ignores
//           stall/flush, and a saturating back-pressure counter.
//           All state updates on the falling edge of clk.
// Ports   : clk, rst (sync, active-low), flush
//           in_valid / in_ready / in_ctrl / in_data    upstream side
//           out_valid / out_ready / out_ctrl / out_data downstream head
//           side_i / side_o                             forwarding lane (1 edge)
//           occupancy (0..2), bp_cnt (saturating stall counter)
// Rev     : 1.0  initial release
// ============================================================================
module pipe_stage_buf #(
    parameter int CTRL_W = 9,
    parameter int DATA_W = 32,
    parameter int SIDE_W = 38,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic [SIDE_W-1:0] side_i,
    output logic [SIDE_W-1:0] side_o,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bp_cnt
);

    logic              w_in_ready;
    logic              w_out_valid;
    logic [CTRL_W-1:0] w_head_ctrl;
    logic [DATA_W-1:0] w_head_data;
    logic [1:0]        w_occ;
    logic              w_accept;
    logic              w_pop;

    assign w_accept = in_valid && w_in_ready;
    assign w_pop    = w_out_valid && out_ready;

    generate
        if (SKID != 0) begin : g_skid
            typedef enum logic [1:0] {
                ST_EMPTY = 2'd0,
                ST_ONE   = 2'd1,
                ST_FULL  = 2'd2
            } state_t;

            state_t            state_q;
            logic              in_ready_q;
            logic              out_valid_q;
            logic [CTRL_W-1:0] head_ctrl_q;
            logic [DATA_W-1:0] head_data_q;
            logic [CTRL_W-1:0] skid_ctrl_q;
            logic [DATA_W-1:0] skid_data_q;

            // in_ready and out_valid are registered copies of the state so
            // the upstream ready path never depends on out_ready.
            always_ff @(negedge clk) begin
                if (!rst || flush) begin
                    state_q     <= ST_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    head_ctrl_q <= '0;
                    head_data_q <= '0;
                    skid_ctrl_q <= '0;
                    skid_data_q <= '0;
                end else begin
                    case (state_q)
                        ST_EMPTY: begin
                            if (w_accept) begin
                                state_q     <= ST_ONE;
                                out_valid_q <= 1'b1;
                                head_ctrl_q <= in_ctrl;
                                head_data_q <= in_data;
                            end
                        end
                        ST_ONE: begin
                            if (w_accept && w_pop) begin
                                head_ctrl_q <= in_ctrl;
                                head_data_q <= in_data;
                            end else if (w_accept) begin
                                // Head is stalled: park the new entry behind it.
                                state_q     <= ST_FULL;
                                in_ready_q  <= 1'b0;
                                skid_ctrl_q <= in_ctrl;
                                skid_data_q <= in_data;
                            end else if (w_pop) begin
                                state_q     <= ST_EMPTY;
                                out_valid_q <= 1'b0;
                                head_ctrl_q <= '0;
                                head_data_q <= '0;
                            end
                        end
                        ST_FULL: begin
                            if (w_pop) begin
                                state_q     <= ST_ONE;
                                in_ready_q  <= 1'b1;
                                head_ctrl_q <= skid_ctrl_q;
                                head_data_q <= skid_data_q;
                                skid_ctrl_q <= '0;
                                skid_data_q <= '0;
                            end
                        end
                        default: begin
                            state_q     <= ST_EMPTY;
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                            head_ctrl_q <= '0;
                            head_data_q <= '0;
                            skid_ctrl_q <= '0;
                            skid_data_q <= '0;
                        end
                    endcase
                end
            end

            assign w_in_ready  = in_ready_q;
            assign w_out_valid = out_valid_q;
            assign w_head_ctrl = head_ctrl_q;
            assign w_head_data = head_data_q;
            assign w_occ       = {state_q == ST_FULL, state_q == ST_ONE};
        end else begin : g_single
            logic              valid_q;
            logic [CTRL_W-1:0] head_ctrl_q;
            logic [DATA_W-1:0] head_data_q;

            always_ff @(negedge clk) begin
                if (!rst || flush) begin
                    valid_q     <= 1'b0;
                    head_ctrl_q <= '0;
                    head_data_q <= '0;
                end else if (w_accept) begin
                    valid_q     <= 1'b1;
                    head_ctrl_q <= in_ctrl;
                    head_data_q <= in_data;
                end else if (w_pop) begin
                    valid_q     <= 1'b0;
                    head_ctrl_q <= '0;
                    head_data_q <= '0;
                end
            end

            // Combinational: a draining head frees the slot on the same edge.
            assign w_in_ready  = !valid_q || out_ready;
            assign w_out_valid = valid_q;
            assign w_head_ctrl = head_ctrl_q;
            assign w_head_data = head_data_q;
            assign w_occ       = {1'b0, valid_q};
        end
    endgenerate

    // Side lane: plain delay register, only reset can clear it.
    logic [SIDE_W-1:0] side_q;
    always_ff @(negedge clk) begin
        side_q <= rst ? side_i : '0;
    end

    // Back-pressure counter keeps counting through flush; sticks at all-ones.
    logic [CNT_W-1:0] bp_cnt_q;
    logic [CNT_W-1:0] bp_cnt_d;
    always_comb begin
        bp_cnt_d = bp_cnt_q;
        if (w_out_valid && !out_ready && (bp_cnt_q != {CNT_W{1'b1}})) begin
            bp_cnt_d = bp_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(negedge clk) begin
        if (!rst) begin
            bp_cnt_q <= '0;
        end else begin
            bp_cnt_q <= bp_cnt_d;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    // Bubble is forced to all-zero so downstream always sees a NOP.
    assign out_ctrl  = w_out_valid ? w_head_ctrl : '0;
    assign out_data  = w_out_valid ? w_head_data : '0;
    assign side_o    = side_q;
    assign occupancy = w_occ;
    assign bp_cnt    = bp_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipe_stage_buf
// Purpose : Self-checking bench for pipe_stage_buf. Drives a skid instance
//           (SKID=1, CNT_W=16) and a single-entry instance (SKID=0, CNT_W=2)
//           from shared inputs, each tracked by its own scoreboard queue.
// Rev     : 1.0  initial release
// ============================================================================
module tb_pipe_stage_buf;

    localparam int CW = 9;
    localparam int DW = 32;
    localparam int SW = 38;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    logic          clk = 1'b1;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic [SW-1:0] side_i = '0;

    logic          a_in_ready, a_out_valid, b_in_ready, b_out_valid;
    logic [CW-1:0] a_out_ctrl, b_out_ctrl;
    logic [DW-1:0] a_out_data, b_out_data;
    logic [SW-1:0] a_side_o, b_side_o;
    logic [1:0]    a_occ, b_occ;
    logic [15:0]   a_bp;
    logic [1:0]    b_bp;

    pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .SIDE_W(SW), .SKID(1), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_ctrl(a_out_ctrl), .out_data(a_out_data),
        .side_i(side_i), .side_o(a_side_o), .occupancy(a_occ), .bp_cnt(a_bp)
    );

    pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .SIDE_W(SW), .SKID(0), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data),
        .side_i(side_i), .side_o(b_side_o), .occupancy(b_occ), .bp_cnt(b_bp)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference state
    ent_t          qa[$];
    ent_t          qb[$];
    logic [15:0]   bpa = '0;
    logic [1:0]    bpb = '0;
    logic [SW-1:0] side_m = '0;

    // One falling edge. Inputs are set by the caller just after a rising edge;
    // handshake checks happen before the edge, state checks at the next rising edge.
    task automatic tick();
        logic acc_a, acc_b, pop_a, pop_b;
        ent_t e;
        ent_t ha, hb;
        #1;
        e     = '{c: in_ctrl, d: in_data};
        pop_a = (qa.size() > 0) && out_ready;
        acc_a = in_valid && (qa.size() < 2);
        pop_b = (qb.size() > 0) && out_ready;
        acc_b = in_valid && ((qb.size() == 0) || out_ready);
        if (rst) begin
            chk("a_in_ready", 64'(a_in_ready), 64'(qa.size() < 2));
            chk("b_in_ready", 64'(b_in_ready), 64'((qb.size() == 0) || out_ready));
            if (pop_a) chk("a_pop", 64'({a_out_ctrl, a_out_data}), 64'(qa[0]));
            if (pop_b) chk("b_pop", 64'({b_out_ctrl, b_out_data}), 64'(qb[0]));
        end
        side_m = rst ? side_i : '0;
        if (!rst) begin
            qa.delete();
            qb.delete();
            bpa = '0;
            bpb = '0;
        end else begin
            if ((qa.size() > 0) && !out_ready && (bpa != 16'hFFFF)) bpa++;
            if ((qb.size() > 0) && !out_ready && (bpb != 2'b11)) bpb++;
            if (flush) begin
                qa.delete();
                qb.delete();
            end else begin
                if (pop_a) void'(qa.pop_front());
                if (acc_a) qa.push_back(e);
                if (pop_b) void'(qb.pop_front());
                if (acc_b) qb.push_back(e);
            end
        end
        @(negedge clk);
        @(posedge clk);
        ha = (qa.size() > 0) ? qa[0] : '0;
        hb = (qb.size() > 0) ? qb[0] : '0;
        chk("a_out_valid", 64'(a_out_valid), 64'(qa.size() > 0));
        chk("a_occ",       64'(a_occ),       64'(qa.size()));
        chk("a_head",      64'({a_out_ctrl, a_out_data}), 64'(ha));
        chk("a_bp",        64'(a_bp),        64'(bpa));
        chk("a_side",      64'(a_side_o),    64'(side_m));
        chk("b_out_valid", 64'(b_out_valid), 64'(qb.size() > 0));
        chk("b_occ",       64'(b_occ),       64'(qb.size()));
        chk("b_head",      64'({b_out_ctrl, b_out_data}), 64'(hb));
        chk("b_bp",        64'(b_bp),        64'(bpb));
        chk("b_side",      64'(b_side_o),    64'(side_m));
    endtask

    task automatic push(input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        in_ctrl  = d[CW-1:0];
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        // Reset held for two edges with a valid offer
        rst = 1'b0; in_valid = 1'b1; in_data = 32'h55; side_i = 38'h3;
        tick();
        tick();
        chk("rst_occ", 64'(a_occ), 64'd0);
        chk("rst_bp",  64'(a_bp),  64'd0);
        chk("rst_side", 64'(a_side_o), 64'd0);
        rst = 1'b1; in_valid = 1'b0;
        tick();
        chk("rst_in_ready", 64'(a_in_ready), 64'd1);

        // Streaming, one entry per edge
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            push(DW'(i));
            chk("stream_data", 64'(a_out_data), 64'(i));
            chk("stream_occ",  64'(a_occ), 64'd1);
        end
        tick();
        tick();

        // Stall fills the skid slot; third offer is refused
        side_i = 38'h15;
        out_ready = 1'b0;
        push(32'hA);
        push(32'hB);
        chk("stall_occ", 64'(a_occ), 64'd2);
        chk("stall_rdy", 64'(a_in_ready), 64'd0);
        push(32'hD);
        tick();
        tick();
        out_ready = 1'b1;
        tick();
        tick();
        tick();

        // Flush while FULL with a simultaneous offer of 0xC
        out_ready = 1'b0;
        push(32'h1);
        push(32'h2);
        flush = 1'b1;
        push(32'hC);
        flush = 1'b0;
        chk("flush_occ",   64'(a_occ), 64'd0);
        chk("flush_valid", 64'(a_out_valid), 64'd0);
        chk("flush_side",  64'(a_side_o), 64'h15);
        out_ready = 1'b1;
        tick();
        tick();

        // Reset while holding entries
        out_ready = 1'b0;
        push(32'h77);
        push(32'h88);
        rst = 1'b0;
        tick();
        chk("midrst_side", 64'(a_side_o), 64'd0);
        rst = 1'b1;
        tick();

        // Saturation of the 2-bit counter and combinational ready of SKID=0
        push(32'h99);
        for (int i = 0; i < 6; i++) tick();
        chk("bp_sat", 64'(b_bp), 64'd3);
        chk("bp_a6",  64'(a_bp), 64'd6);
        out_ready = 1'b1;
        #1 chk("comb_rdy1", 64'(b_in_ready), 64'd1);
        out_ready = 1'b0;
        #1 chk("comb_rdy0", 64'(b_in_ready), 64'd0);
        out_ready = 1'b1;
        tick();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            rst       = ($urandom_range(0, 49) != 0);
            in_data   = $urandom;
            in_ctrl   = CW'($urandom);
            side_i    = {6'($urandom), 32'($urandom)};
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
